// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects and strobes; illegal_op is a sticky unsupported-opcode flag.
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       illegal_op
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StRWb    = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9,
    StAddiEx = 4'd10,
    StAddiWb = 4'd11
  } state_e;

  // Moore part of the control word; FETCH's ir_write/pc_write are Mealy and live outside.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  function automatic ctrl_t ctrl_for(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      StFetch: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'd1;
      end
      StDecode: c.alu_src_b = 2'd3;
      StMemAdr: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd2;
      end
      StMemRd: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      StMemWb: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      StMemWr: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      StExec: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'd2;
      end
      StRWb: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      StBranch: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'd1;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'd1;
      end
      StJump: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'd2;
      end
      StAddiEx: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd2;
      end
      StAddiWb: c.reg_write = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  localparam ctrl_t FetchCtrl = ctrl_for(StFetch);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   fetch_ack;
  logic   unused_zero;

  // Branch resolution happens in the PC-write logic outside this block.
  assign unused_zero = zero;

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      StFetch: if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExec;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
          OpAddi:     state_d = StAddiEx;
          default: begin
            state_d   = StFetch;
            illegal_d = 1'b1;
          end
        endcase
      end
      StMemAdr: state_d = (opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd:  if (mem_ready) state_d = StMemWb;
      StMemWr:  if (mem_ready) state_d = StFetch;
      StExec:   state_d = StRWb;
      StAddiEx: state_d = StAddiWb;
      default:  state_d = StFetch;
    endcase
    ctrl_d = ctrl_for(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
      ctrl_q    <= FetchCtrl;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign fetch_ack = (state_q == StFetch) && mem_ready;

  // Strobes are gated by rst_n so nothing writes while reset is held.
  assign pc_write      = rst_n & (ctrl_q.pc_write | fetch_ack);
  assign ir_write      = rst_n & fetch_ack;
  assign pc_write_cond = rst_n & ctrl_q.pc_write_cond;
  assign mem_read      = rst_n & ctrl_q.mem_read;
  assign mem_write     = rst_n & ctrl_q.mem_write;
  assign reg_write     = rst_n & ctrl_q.reg_write;
  assign i_or_d        = ctrl_q.i_or_d;
  assign mem_to_reg    = ctrl_q.mem_to_reg;
  assign reg_dst       = ctrl_q.reg_dst;
  assign alu_src_a     = ctrl_q.alu_src_a;
  assign alu_src_b     = ctrl_q.alu_src_b;
  assign alu_op        = ctrl_q.alu_op;
  assign pc_source     = ctrl_q.pc_source;
  assign state         = state_q;
  assign illegal_op    = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-level plans give the expected state per cycle,
// a per-state output table gives the expected control word, checked every negedge.
module tb_multicycle_control;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [5:0] opcode;
  logic       zero, mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic       illegal_op;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .illegal_op(illegal_op)
  );

  logic [15:0] dut_vec;
  assign dut_vec = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                    mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

  int checks = 0;
  int errors = 0;
  int exp_st = 0;
  bit exp_rst = 1'b1;
  bit exp_valid = 1'b0;
  bit ill = 1'b0;
  int zmode = -1;
  int hist_st[$];
  int hist_irw[$];
  int want[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, got, exp);
    end
  endtask

  task automatic check_q(input string name, input int got[$], input int exp[$]);
    bit bad;
    bad = (got.size() != exp.size());
    if (!bad) foreach (exp[i]) if (got[i] != exp[i]) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s: got %p want %p", name, got, exp);
    end
  endtask

  // Expected control word for a state, straight from the per-state output rules.
  function automatic logic [15:0] exp_ctrl(input int st, input bit ack);
    bit pw = 0, pwc = 0, iod = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rdst = 0, rw = 0, asa = 0;
    bit [1:0] asb = 0, aop = 0, psrc = 0;
    case (st)
      0:  begin mrd = 1; asb = 1; irw = ack; pw = ack; end
      1:  asb = 3;
      2:  begin asa = 1; asb = 2; end
      3:  begin mrd = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iod = 1; end
      6:  begin asa = 1; aop = 2; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin asa = 1; aop = 1; pwc = 1; psrc = 1; end
      9:  begin pw = 1; psrc = 2; end
      10: begin asa = 1; asb = 2; end
      11: rw = 1;
      default: ;
    endcase
    return {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc};
  endfunction

  function automatic bit legal(input logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
  endfunction

  always @(negedge clk) begin
    if (exp_valid) begin
      hist_st.push_back(int'(state));
      hist_irw.push_back(int'({ir_write, pc_write}));
      check("state", state, exp_rst ? 0 : exp_st);
      if (exp_rst)
        check("reset_strobes",
              {pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write}, 0);
      else
        check("ctrl", dut_vec, exp_ctrl(exp_st, mem_ready));
      check("illegal_op", illegal_op, ill);
      check("excl", (mem_read & mem_write) | (pc_write & pc_write_cond), 0);
    end
  end

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Drive one cycle starting at posedge+1: inputs and the state the plan says we are in.
  task automatic cyc(input int st, input bit mr, input logic [5:0] op);
    opcode = op;
    mem_ready = mr;
    zero = (zmode < 0) ? rb() : zmode[0];
    exp_st = st;
    @(posedge clk);
    #1;
    if (st == 1 && !legal(op)) ill = 1'b1;
  endtask

  task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
    repeat (wf) cyc(0, 1'b0, 6'($urandom));
    cyc(0, 1'b1, 6'($urandom));
    cyc(1, rb(), op);
    case (op)
      OP_LW: begin
        cyc(2, rb(), op);
        repeat (wm) cyc(3, 1'b0, op);
        cyc(3, 1'b1, op);
        cyc(4, rb(), op);
      end
      OP_SW: begin
        cyc(2, rb(), op);
        repeat (wm) cyc(5, 1'b0, op);
        cyc(5, 1'b1, op);
      end
      OP_R:    begin cyc(6, rb(), op); cyc(7, rb(), op); end
      OP_BEQ:  cyc(8, rb(), op);
      OP_J:    cyc(9, rb(), op);
      OP_ADDI: begin cyc(10, rb(), op); cyc(11, rb(), op); end
      default: ;
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op;
    int r;
    rst_n = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
    #2 rst_n = 1'b0;
    exp_valid = 1'b1;
    #1;
    check("reset_state_async", state, 0);
    check("reset_illegal", illegal_op, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_rst = 1'b0;

    // lw with mem_ready high throughout, then j
    hist_st.delete();
    zmode = -1;
    run_instr(OP_LW, 0, 0);
    run_instr(OP_J, 0, 0);
    want = '{0, 1, 2, 3, 4, 0, 1, 9};
    check_q("lw_j_states", hist_st, want);

    // sw held 3 extra cycles in MEM_WR
    hist_st.delete();
    run_instr(OP_SW, 0, 3);
    want = '{0, 1, 2, 5, 5, 5, 5};
    check_q("sw_wait_states", hist_st, want);
    check("sw_back_to_fetch", state, 0);

    // beq taken and not taken behave identically here
    hist_st.delete();
    zmode = 1;
    run_instr(OP_BEQ, 0, 0);
    zmode = 0;
    run_instr(OP_BEQ, 0, 0);
    zmode = -1;
    want = '{0, 1, 8, 0, 1, 8};
    check_q("beq_states", hist_st, want);

    // illegal opcode then a normal R-type
    run_instr(6'b111111, 0, 0);
    check("illegal_set", illegal_op, 1);
    hist_st.delete();
    run_instr(OP_R, 0, 0);
    want = '{0, 1, 6, 7};
    check_q("r_after_illegal", hist_st, want);
    check("illegal_sticky", illegal_op, 1);

    // reset mid-EXEC, held 2 cycles
    cyc(0, 1'b1, 6'($urandom));
    cyc(1, 1'b0, OP_R);
    opcode = OP_R; mem_ready = 1'b1; exp_st = 6;
    #1 rst_n = 1'b0;
    exp_rst = 1'b1;
    ill = 1'b0;
    #1;
    check("midexec_reset_state", state, 0);
    check("midexec_reset_regwrite", reg_write, 0);
    check("midexec_reset_illegal", illegal_op, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_rst = 1'b0;

    // FETCH waits 5 cycles before ack, then j
    hist_st.delete();
    hist_irw.delete();
    run_instr(OP_J, 5, 0);
    want = '{0, 0, 0, 0, 0, 0, 1, 9};
    check_q("fetch_wait_states", hist_st, want);
    want = '{0, 0, 0, 0, 0, 3, 0, 1};
    check_q("fetch_wait_irw_pcw", hist_irw, want);

    // randomized instruction stream
    repeat (300) begin
      r = $urandom_range(0, 12);
      case (r)
        0, 1:  op = OP_LW;
        2, 3:  op = OP_SW;
        4, 5:  op = OP_R;
        6, 7:  op = OP_BEQ;
        8:     op = OP_J;
        9, 10: op = OP_ADDI;
        default: op = 6'($urandom);
      endcase
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    exp_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters: none; opcode values, state encodings and widths are fixed by this document.
REQ-002 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 opcode  input  6  instruction[31:26] from the instruction register; sampled only in DECODE.
REQ-005 zero  input  1  ALU zero flag; used only in BRANCH.
REQ-006 mem_ready  input  1  memory ack; 1 = current read/write completes this cycle.
REQ-007 pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write  output  1 each  PC, memory and instruction-register controls.
REQ-008 mem_to_reg, reg_dst, reg_write, alu_src_a  output  1 each  register-file and ALU-input select.
REQ-009 alu_src_b  output  2  ALU B select: 0 = regB, 1 = const 4, 2 = sign-ext, 3 = sign-ext<<2.
REQ-010 alu_op  output  2  0 = add, 1 = subtract, 2 = decode funct field.
REQ-011 pc_source  output  2  0 = ALU result, 1 = ALUOut register, 2 = jump address.
REQ-012 state  output  4  current state encoding, for debug.
REQ-013 illegal_op  output  1  sticky flag; set on an unsupported opcode.

Function
REQ-014 States and encodings: FETCH 0, DECODE 1, MEM_ADR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EX 10, ADDI_WB 11; encodings 12-15 are unreachable and go to FETCH.
REQ-015 Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
REQ-016 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0.
REQ-017 FETCH, continued: ir_write=1 and pc_write=1 only in the cycle mem_ready=1 (Mealy).
REQ-018 FETCH: stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
REQ-019 DECODE: alu_src_a=0, alu_src_b=3, alu_op=0 (branch target into ALUOut).
REQ-020 DECODE next state: lw/sw -> MEM_ADR, R-type -> EXEC, beq -> BRANCH, j -> JUMP, addi -> ADDI_EX.
REQ-021 DECODE, any other opcode: next state FETCH, and illegal_op is set.
REQ-022 MEM_ADR: alu_src_a=1, alu_src_b=2, alu_op=0; next state MEM_RD for lw, MEM_WR for sw (opcode held stable by the IR).
REQ-023 MEM_RD: mem_read=1, i_or_d=1; stay while mem_ready=0; go to MEM_WB when mem_ready=1.
REQ-024 MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1; next state FETCH.
REQ-025 MEM_WR: mem_write=1, i_or_d=1; stay while mem_ready=0; go to FETCH when mem_ready=1.
REQ-026 EXEC: alu_src_a=1, alu_src_b=0, alu_op=2; next state R_WB.
REQ-027 R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; next state FETCH.
REQ-028 BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_source=1; next state FETCH.
REQ-029 JUMP: pc_write=1, pc_source=2; next state FETCH.
REQ-030 ADDI_EX: alu_src_a=1, alu_src_b=2, alu_op=0; next state ADDI_WB.
REQ-031 ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0; next state FETCH.
REQ-032 Any output not listed for a state is 0 in that state.
REQ-033 Mutual exclusion, every cycle: mem_read and mem_write never both 1; at most one of pc_write/pc_write_cond is 1.
REQ-034 Cycle counts at mem_ready=1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3; each cycle mem_ready is low in a memory state adds exactly one cycle.
REQ-035 illegal_op stays 1 until reset and does not otherwise alter sequencing.

Reset
REQ-036 rst_n=0: state goes to FETCH immediately (asynchronously), and illegal_op clears to 0.
REQ-037 While rst_n=0, all 1-bit write/strobe outputs are forced to 0 regardless of state (pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write).
REQ-038 Reset asserted mid-instruction abandons that instruction; no partial register or memory write occurs after the assertion.
REQ-039 After release, the first rising edge evaluates FETCH.

Verification
REQ-040 Reset, then lw with mem_ready tied 1 -> states 0,1,2,3,4,0; reg_write=1 only in state 4, with mem_to_reg=1.
REQ-041 sw with mem_ready low 3 cycles in MEM_WR -> state 5 held 4 cycles; mem_write=1 throughout; then state 0.
REQ-042 beq with zero=1, then beq with zero=0 -> pc_write_cond=1 and pc_source=1 in state 8 for both; each takes 3 cycles.
REQ-043 Opcode 111111 -> DECODE to FETCH, illegal_op rises and stays 1; following R-type completes normally in 4 cycles.
REQ-044 rst_n dropped mid-EXEC and held 2 cycles -> state=0 immediately; reg_write never asserts; illegal_op=0.
REQ-045 FETCH with mem_ready=0 for 5 cycles -> ir_write=0 and pc_write=0 for those 5 cycles; both =1 in the single ack cycle.
